// File: rtl/l1_sdram_arbiter_pkg.sv
// Shared definitions for the L1I/L1D SDRAM arbiter: FSM encoding, port IDs,
// width defaults and the round-robin grant helper.
package l1_sdram_arbiter_pkg;

    localparam int DEF_ADDR_W = 27;
    localparam int DEF_DATA_W = 32;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;

    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

    // A lone requester wins; on a tie the port that was not granted last wins.
    function automatic logic next_grant(input logic i_pend, input logic d_pend,
                                        input logic last_grant);
        if (i_pend && d_pend)
            return (last_grant == PORT_I) ? PORT_D : PORT_I;
        else if (i_pend)
            return PORT_I;
        else
            return PORT_D;
    endfunction

endpackage

// File: rtl/l1_sdram_arbiter_req_latch.sv
// One-deep request latch for a single L1 port. The pending flag stays set while
// the request is queued or in flight, so ready is simply "alive and not pending".
module arb_req_latch #(
    parameter int AW = 27,
    parameter int DW = 32
) (
    input  logic          clk100,
    input  logic          reset,
    input  logic          i_start,
    input  logic [AW-1:0] i_addr,
    input  logic [DW-1:0] i_data,
    input  logic          i_we,
    input  logic          i_clear,
    output logic          o_pending,
    output logic          o_ready,
    output logic [AW-1:0] o_addr,
    output logic [DW-1:0] o_data,
    output logic          o_we
);

    logic          r_alive;
    logic          r_pending;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_data;
    logic          r_we;
    logic          w_ready;

    // r_alive keeps ready low throughout reset and raises it on the first edge after.
    assign w_ready = r_alive && !r_pending;

    always_ff @(posedge clk100) begin
        if (!reset) begin
            r_alive   <= 1'b0;
            r_pending <= 1'b0;
            r_addr    <= '0;
            r_data    <= '0;
            r_we      <= 1'b0;
        end else begin
            r_alive <= 1'b1;
            if (i_clear) begin
                r_pending <= 1'b0;
            end else if (i_start && w_ready) begin
                r_pending <= 1'b1;
                r_addr    <= i_addr;
                r_data    <= i_data;
                r_we      <= i_we;
            end
        end
    end

    assign o_pending = r_pending;
    assign o_ready   = w_ready;
    assign o_addr    = r_addr;
    assign o_data    = r_data;
    assign o_we      = r_we;

endmodule

// File: rtl/l1_sdram_arbiter.sv
// Round-robin arbiter sharing one SDRAM controller between L1I (read-only) and
// L1D. Valid/ready: a start pulse is accepted only when that port's ready is high.
module l1_sdram_arbiter
    import l1_sdram_arbiter_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk100,
    input  logic              reset,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              i_start,
    output logic [DATA_W-1:0] i_q,
    output logic              i_done,
    output logic              i_ready,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_data,
    input  logic              d_we,
    input  logic              d_start,
    output logic [DATA_W-1:0] d_q,
    output logic              d_done,
    output logic              d_ready,
    output logic [ADDR_W-1:0] sdc_addr,
    output logic [DATA_W-1:0] sdc_data,
    output logic              sdc_we,
    output logic              sdc_start,
    input  logic [DATA_W-1:0] sdc_q,
    input  logic              sdc_done,
    input  logic              sdc_ready,
    output logic [1:0]        o_dbg_state
);

    logic [1:0]        r_state;
    logic              r_grant;
    logic              r_last_grant;
    logic [ADDR_W-1:0] r_sdc_addr;
    logic [DATA_W-1:0] r_sdc_data;
    logic              r_sdc_we;
    logic              r_sdc_start;
    logic [DATA_W-1:0] r_i_q;
    logic [DATA_W-1:0] r_d_q;
    logic              r_i_done;
    logic              r_d_done;

    logic              w_i_pend;
    logic              w_d_pend;
    logic [ADDR_W-1:0] w_i_addr;
    logic [ADDR_W-1:0] w_d_addr;
    logic [DATA_W-1:0] w_i_data;
    logic [DATA_W-1:0] w_d_data;
    logic              w_i_we;
    logic              w_d_we;
    logic              w_done_hit;
    logic              w_i_clear;
    logic              w_d_clear;
    logic              w_next;

    assign w_done_hit = (r_state == ST_WAIT) && sdc_done;
    assign w_i_clear  = w_done_hit && (r_grant == PORT_I);
    assign w_d_clear  = w_done_hit && (r_grant == PORT_D);
    assign w_next     = next_grant(w_i_pend, w_d_pend, r_last_grant);

    // The I latch has its data/we tied to zero, so an I issue drives sdc_data=0, sdc_we=0.
    arb_req_latch #(.AW(ADDR_W), .DW(DATA_W)) u_i_latch (
        .clk100    (clk100),
        .reset     (reset),
        .i_start   (i_start),
        .i_addr    (i_addr),
        .i_data    ('0),
        .i_we      (1'b0),
        .i_clear   (w_i_clear),
        .o_pending (w_i_pend),
        .o_ready   (i_ready),
        .o_addr    (w_i_addr),
        .o_data    (w_i_data),
        .o_we      (w_i_we)
    );

    arb_req_latch #(.AW(ADDR_W), .DW(DATA_W)) u_d_latch (
        .clk100    (clk100),
        .reset     (reset),
        .i_start   (d_start),
        .i_addr    (d_addr),
        .i_data    (d_data),
        .i_we      (d_we),
        .i_clear   (w_d_clear),
        .o_pending (w_d_pend),
        .o_ready   (d_ready),
        .o_addr    (w_d_addr),
        .o_data    (w_d_data),
        .o_we      (w_d_we)
    );

    always_ff @(posedge clk100) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_grant      <= PORT_D;
            r_last_grant <= PORT_D;
            r_sdc_addr   <= '0;
            r_sdc_data   <= '0;
            r_sdc_we     <= 1'b0;
            r_sdc_start  <= 1'b0;
            r_i_q        <= '0;
            r_d_q        <= '0;
            r_i_done     <= 1'b0;
            r_d_done     <= 1'b0;
        end else begin
            r_sdc_start <= 1'b0;
            r_i_done    <= 1'b0;
            r_d_done    <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if ((w_i_pend || w_d_pend) && sdc_ready) begin
                        r_state      <= ST_ISSUE;
                        r_grant      <= w_next;
                        r_last_grant <= w_next;
                        r_sdc_start  <= 1'b1;
                        r_sdc_addr   <= (w_next == PORT_I) ? w_i_addr : w_d_addr;
                        r_sdc_data   <= (w_next == PORT_I) ? w_i_data : w_d_data;
                        r_sdc_we     <= (w_next == PORT_I) ? w_i_we   : w_d_we;
                    end
                end
                ST_ISSUE: begin
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (sdc_done) begin
                        r_state <= ST_IDLE;
                        if (r_grant == PORT_I) begin
                            r_i_q    <= sdc_q;
                            r_i_done <= 1'b1;
                        end else begin
                            r_d_q    <= sdc_q;
                            r_d_done <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign sdc_addr    = r_sdc_addr;
    assign sdc_data    = r_sdc_data;
    assign sdc_we      = r_sdc_we;
    assign sdc_start   = r_sdc_start;
    assign i_q         = r_i_q;
    assign d_q         = r_d_q;
    assign i_done      = r_i_done;
    assign d_done      = r_d_done;
    assign o_dbg_state = r_state;

endmodule
